// File: rtl/sipo_deserializer_if.sv
// Word-side bundle of the serial-to-parallel deserializer: serial bit input,
// clear strobe, and the valid/ready output register with status flags.
interface sipo_deserializer_if #(
    parameter int WIDTH = 4
) ();
    logic             serial_i;
    logic             valid_i;
    logic             clear_i;
    logic             ready_i;
    logic [WIDTH-1:0] parallel_o;
    logic             valid_o;
    logic             busy_o;
    logic             overflow_o;

    // The deserializer itself.
    modport slave (
        input  serial_i, valid_i, clear_i, ready_i,
        output parallel_o, valid_o, busy_o, overflow_o
    );

    // The serial source / word consumer side.
    modport master (
        output serial_i, valid_i, clear_i, ready_i,
        input  parallel_o, valid_o, busy_o, overflow_o
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: collects WIDTH qualified serial bits into
// a word and presents it on a single-entry valid/ready output register.
module sipo_deserializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    sipo_deserializer_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [CW-1:0]    count_q,    count_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic [WIDTH-1:0] parallel_q, parallel_d;
    logic             valid_q,    valid_d;
    logic             busy_q,     busy_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] shift_in;
    logic             accept;
    logic             complete;
    logic             slot_free;

    // Shift-register input wiring; the branch taken fixes which end a new bit enters.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (LSB_FIRST) begin : g_lsb
                if (gi == WIDTH - 1) begin : g_end
                    assign shift_in[gi] = bus.serial_i;
                end else begin : g_mid
                    assign shift_in[gi] = shift_q[gi + 1];
                end
            end else begin : g_msb
                if (gi == 0) begin : g_end
                    assign shift_in[gi] = bus.serial_i;
                end else begin : g_mid
                    assign shift_in[gi] = shift_q[gi - 1];
                end
            end
        end
    endgenerate

    assign accept    = bus.valid_i && !bus.clear_i;
    assign complete  = accept && (count_q == LAST_BIT);
    assign slot_free = !valid_q || bus.ready_i;

    always_comb begin
        count_d    = count_q;
        shift_d    = shift_q;
        parallel_d = parallel_q;
        valid_d    = valid_q;
        overflow_d = 1'b0;

        if (bus.clear_i) begin
            count_d = '0;
            shift_d = '0;
        end else if (accept) begin
            shift_d = shift_in;
            count_d = complete ? '0 : count_q + CW'(1);
        end

        // A word completing into a free slot overrides the consume, so
        // back-to-back words keep valid high with no bubble.
        if (complete && slot_free) begin
            parallel_d = shift_in;
            valid_d    = 1'b1;
        end else if (complete) begin
            overflow_d = 1'b1;
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            shift_q    <= '0;
            parallel_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            shift_q    <= shift_d;
            parallel_q <= parallel_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.parallel_o = parallel_q;
    assign bus.valid_o    = valid_q;
    assign bus.busy_o     = busy_q;
    assign bus.overflow_o = overflow_q;

    // A held word must stay put until it is taken; a drop can never repeat on the next edge.
    a_hold_stable: assert property (@(posedge clk) disable iff (reset)
        (valid_q && !bus.ready_i) |=> $stable(parallel_q));
    a_overflow_pulse: assert property (@(posedge clk) disable iff (reset)
        overflow_q |=> !overflow_q);
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: two deserializers (LSB-first and MSB-first) driven with the
// same serial stream and checked against hand-computed expected outputs.
module tb_sipo_deserializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(4)) bus_l ();
    sipo_deserializer_if #(.WIDTH(4)) bus_m ();

    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_l (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_l.slave)
    );
    sipo_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_m (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m.slave)
    );

    typedef struct {
        logic       v, s, c, r;
        logic [3:0] pl, pm;
        logic       vo, bo, ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic s, logic c, logic r,
                                logic [3:0] pl, logic [3:0] pm,
                                logic vo, logic bo, logic ov);
        vec_t x;
        x.v = v; x.s = s; x.c = c; x.r = r;
        x.pl = pl; x.pm = pm; x.vo = vo; x.bo = bo; x.ov = ov;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic c, input logic r);
        bus_l.valid_i = v; bus_l.serial_i = s; bus_l.clear_i = c; bus_l.ready_i = r;
        bus_m.valid_i = v; bus_m.serial_i = s; bus_m.clear_i = c; bus_m.ready_i = r;
    endtask

    task automatic send(input logic v, input logic s, input logic c, input logic r);
        drive(v, s, c, r);
        @(posedge clk);
        #1;
        $display("t=%0t v=%b s=%b clr=%b rdy=%b -> par_l=%h par_m=%h valid=%b busy=%b ovf=%b",
                 $time, v, s, c, r, bus_l.parallel_o, bus_m.parallel_o,
                 bus_l.valid_o, bus_l.busy_o, bus_l.overflow_o);
    endtask

    task automatic chk_both(input string nm, input logic [3:0] pl, input logic [3:0] pm,
                            input logic vo, input logic bo, input logic ov);
        chk({nm, " par_l"}, 32'(bus_l.parallel_o), 32'(pl));
        chk({nm, " par_m"}, 32'(bus_m.parallel_o), 32'(pm));
        chk({nm, " valid_l"}, 32'(bus_l.valid_o), 32'(vo));
        chk({nm, " valid_m"}, 32'(bus_m.valid_o), 32'(vo));
        chk({nm, " busy"}, 32'(bus_l.busy_o), 32'(bo));
        chk({nm, " ovf"}, 32'(bus_l.overflow_o), 32'(ov));
    endtask

    initial begin
        //                v  s  c  r   par_l  par_m  vo bo ov
        // Single word, ready high
        tbl.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 4'h0, 4'h0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'h0, 4'h0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'hD, 4'hB, 0, 0, 0));
        // Ready low: first word held, second dropped with overflow pulse
        tbl.push_back(mk(1, 1, 0, 0, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'hD, 4'hB, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'hD, 4'hB, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'hD, 4'hB, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'hD, 4'hB, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'hD, 4'hB, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4'hD, 4'hB, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'hD, 4'hB, 0, 0, 0));
        // Two continuous words, ready high, no overflow
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 4'h6, 4'h6, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'h6, 4'h6, 1, 0, 0));
        // Consume and complete on the same edge: valid stays high
        tbl.push_back(mk(1, 1, 0, 0, 4'h6, 4'h6, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 4'h6, 4'h6, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 4'h6, 4'h6, 1, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'hD, 4'hB, 0, 0, 0));
        // Clear with a bit on the same edge, then a fresh word
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 4'hD, 4'hB, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 4'hD, 4'hB, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 4'h6, 4'h6, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 4'h6, 4'h6, 1, 0, 0));
        // Clear leaves a held output word untouched
        tbl.push_back(mk(1, 1, 1, 0, 4'h6, 4'h6, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4'h6, 4'h6, 0, 0, 0));

        drive(0, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_both("reset", 4'h0, 4'h0, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].r);
            chk_both($sformatf("vec%0d", i), tbl[i].pl, tbl[i].pm, tbl[i].vo, tbl[i].bo, tbl[i].ov);
        end

        // Gap in valid_i between bits 2 and 3: busy holds, same words result
        send(1, 1, 0, 1);
        send(1, 0, 0, 1);
        for (int g = 0; g < 3; g++) begin
            send(0, 1, 0, 1);
            chk_both($sformatf("gap%0d", g), 4'h6, 4'h6, 0, 1, 0);
        end
        send(1, 1, 0, 1);
        chk_both("gap bit3", 4'h6, 4'h6, 0, 1, 0);
        send(1, 1, 0, 1);
        chk_both("gap word", 4'hD, 4'hB, 1, 0, 0);
        send(0, 0, 0, 1);
        chk_both("gap consume", 4'hD, 4'hB, 0, 0, 0);

        // Asynchronous reset with a held word and a partial word in flight
        send(1, 0, 0, 0);
        send(1, 1, 0, 0);
        send(1, 1, 0, 0);
        send(1, 0, 0, 0);
        chk_both("pre-reset held", 4'h6, 4'h6, 1, 0, 0);
        send(1, 1, 0, 0);
        send(1, 1, 0, 0);
        send(1, 1, 0, 0);
        chk_both("pre-reset partial", 4'h6, 4'h6, 1, 1, 0);
        drive(0, 0, 0, 1);
        #2;
        reset = 1'b1;
        #1;
        chk_both("async reset", 4'h0, 4'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(1, 1, 0, 1);
        send(1, 1, 0, 1);
        send(1, 1, 0, 1);
        chk_both("post-reset partial", 4'h0, 4'h0, 0, 1, 0);
        send(1, 1, 0, 1);
        chk_both("post-reset word", 4'hF, 4'hF, 1, 0, 0);
        send(0, 0, 0, 1);
        chk_both("post-reset consume", 4'hF, 4'hF, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
